// File: rtl/note_lane_engine.sv
// Falling-note rhythm engine: plays a lane-mask pattern as scrolling rows, judges
// per-lane hits against a hit line, keeps score/miss tallies and renders note pixels.
module note_lane_engine #(
  parameter int LANES      = 3,
  parameter int DEPTH      = 8,
  parameter int SLOTS      = 8,
  parameter int SPEED      = 1,
  parameter int SPAWN_GAP  = 60,
  parameter int HIT_Y      = 440,
  parameter int HIT_WIN    = 10,
  parameter int NOTE_HALF  = 10,
  parameter int LANE_PITCH = 220,
  parameter int LANE_W     = 200,
  parameter int SCORE_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     frame_tick,
  input  logic [LANES-1:0]         hit_btn,
  input  logic                     pat_we,
  input  logic [$clog2(DEPTH)-1:0] pat_addr,
  input  logic [LANES-1:0]         pat_wdata,
  input  logic [9:0]               counter_x,
  input  logic [9:0]               counter_y,
  output logic [LANES-1:0]         pixel_on,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       misses,
  output logic [$clog2(SLOTS):0]   active_rows,
  output logic                     overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SW   = $clog2(SLOTS);
  localparam int CW   = SW + 1;
  localparam int GW   = $clog2(SPAWN_GAP + 1);
  localparam int SMAX = (1 << SCORE_W) - 1;
  localparam int Y_LO = HIT_Y - HIT_WIN;
  localparam int Y_HI = HIT_Y + HIT_WIN;

  logic [LANES-1:0]            pattern [DEPTH];
  logic [SLOTS-1:0]            slot_valid, valid_n;
  logic [SLOTS-1:0][9:0]       slot_y, y_n;
  logic [SLOTS-1:0][LANES-1:0] slot_mask, mask_hit, mask_n;
  logic [AW-1:0]               idx, idx_n;
  logic [GW-1:0]               spawn_cnt, cnt_n;
  logic [SCORE_W-1:0]          score_n, misses_n;
  logic [CW-1:0]               active_n;
  logic                        overflow_n;
  logic [LANES-1:0]            pixel_n;
  logic [LANES-1:0]            spawn_row;
  logic                        tick, claimed;
  int                          hit_cnt, miss_cnt, kept, y_adv;

  always_ff @(posedge clk) begin
    if (pat_we) pattern[pat_addr] <= pat_wdata;
  end

  // Slot 0 is always the oldest row, so the first eligible slot per lane wins the press.
  always_comb begin
    mask_hit = slot_mask;
    hit_cnt  = 0;
    claimed  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      claimed = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        if (enable && hit_btn[i] && !claimed && slot_valid[s] && slot_mask[s][i] &&
            int'(slot_y[s]) >= Y_LO && int'(slot_y[s]) <= Y_HI) begin
          mask_hit[s][i] = 1'b0;
          claimed        = 1'b1;
          hit_cnt++;
        end
      end
    end
  end

  // Survivors are packed toward slot 0 in age order; a new row is appended behind them.
  always_comb begin
    tick     = enable & frame_tick;
    valid_n  = '0;
    y_n      = '0;
    mask_n   = '0;
    kept     = 0;
    miss_cnt = 0;
    y_adv    = 0;
    for (int s = 0; s < SLOTS; s++) begin
      if (slot_valid[s] && mask_hit[s] != '0) begin
        y_adv = int'(slot_y[s]) + (tick ? SPEED : 0);
        if (y_adv > Y_HI) begin
          miss_cnt += $countones(mask_hit[s]);
        end else begin
          valid_n[SW'(kept)] = 1'b1;
          y_n[SW'(kept)]     = 10'(y_adv);
          mask_n[SW'(kept)]  = mask_hit[s];
          kept++;
        end
      end
    end

    idx_n      = idx;
    cnt_n      = spawn_cnt;
    overflow_n = overflow;
    spawn_row  = pattern[idx];
    if (tick) begin
      if (spawn_cnt == '0) begin
        cnt_n = GW'(SPAWN_GAP - 1);
        if (spawn_row == '0) begin
          idx_n = idx + 1'b1;
        end else if (kept < SLOTS) begin
          valid_n[SW'(kept)] = 1'b1;
          y_n[SW'(kept)]     = '0;
          mask_n[SW'(kept)]  = spawn_row;
          kept++;
          idx_n = idx + 1'b1;
        end else begin
          overflow_n = 1'b1;
        end
      end else begin
        cnt_n = spawn_cnt - 1'b1;
      end
    end

    active_n = CW'(kept);
    score_n  = (int'(score) + hit_cnt > SMAX) ? SCORE_W'(SMAX) : SCORE_W'(int'(score) + hit_cnt);
    misses_n = (int'(misses) + miss_cnt > SMAX) ? SCORE_W'(SMAX) : SCORE_W'(int'(misses) + miss_cnt);
  end

  // Lower bound written as y+NOTE_HALF >= note_y, which also covers the clamp at row 0.
  always_comb begin
    pixel_n = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (slot_valid[s] && slot_mask[s][i] &&
            int'(counter_x) >= i * LANE_PITCH &&
            int'(counter_x) <= i * LANE_PITCH + LANE_W - 1 &&
            int'(counter_y) + NOTE_HALF >= int'(slot_y[s]) &&
            int'(counter_y) <= int'(slot_y[s]) + NOTE_HALF) begin
          pixel_n[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid  <= '0;
      slot_y      <= '0;
      slot_mask   <= '0;
      idx         <= '0;
      spawn_cnt   <= '0;
      score       <= '0;
      misses      <= '0;
      overflow    <= 1'b0;
      active_rows <= '0;
      pixel_on    <= '0;
    end else begin
      slot_valid  <= valid_n;
      slot_y      <= y_n;
      slot_mask   <= mask_n;
      idx         <= idx_n;
      spawn_cnt   <= cnt_n;
      score       <= score_n;
      misses      <= misses_n;
      overflow    <= overflow_n;
      active_rows <= active_n;
      pixel_on    <= pixel_n;
    end
  end

endmodule
